// File: rtl/juggle_pkg.sv
// Shared types and constants for the juggling throw scheduler.
package juggle_pkg;

    localparam int MAX_PATTERN_LEN = 7;
    localparam int MAX_HEIGHT      = 7;
    localparam int BALL_ID_W       = 3;
    localparam int HEIGHT_W        = $clog2(MAX_HEIGHT + 1);

    typedef struct packed {
        logic                 valid;
        logic [BALL_ID_W-1:0] id;
    } slot_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        ERROR = 2'd2
    } sched_state_t;

endpackage

// File: rtl/landing_table.sv
// Landing table: one slot per future beat, holding the ball due to land then.
// Combinational read at the beat pointer; a write to a slot wins over a clear of it.
module landing_table
    import juggle_pkg::*;
#(
    parameter int TABLE_DEPTH = 8,
    localparam int ADDR_W = $clog2(TABLE_DEPTH)
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 clear_all,
    input  logic [ADDR_W-1:0]    rd_addr,
    output slot_t                rd_slot,
    input  logic                 clr_en,
    input  logic [ADDR_W-1:0]    clr_addr,
    input  logic                 wr_en,
    input  logic [ADDR_W-1:0]    wr_addr,
    input  logic [BALL_ID_W-1:0] wr_id,
    output logic                 wr_occupied
);

    slot_t [TABLE_DEPTH-1:0] slot_view;

    generate
        for (genvar gi = 0; gi < TABLE_DEPTH; gi++) begin : g_slot
            slot_t slot_reg;

            always_ff @(posedge clk_in) begin
                if (rst_in || clear_all) begin
                    slot_reg <= '0;
                end else if (wr_en && (wr_addr == ADDR_W'(gi))) begin
                    slot_reg.valid <= 1'b1;
                    slot_reg.id    <= wr_id;
                end else if (clr_en && (clr_addr == ADDR_W'(gi))) begin
                    slot_reg.valid <= 1'b0;
                end
            end

            assign slot_view[gi] = slot_reg;
        end
    endgenerate

    assign rd_slot     = slot_view[rd_addr];
    assign wr_occupied = slot_view[wr_addr].valid;

endmodule

// File: rtl/juggle_scheduler.sv
// Beat-driven siteswap throw scheduler with one registered throw event per beat.
// Optional macro JUGGLE_COLLISION_CHECK_EN: a throw onto an occupied slot raises ERROR.
module juggle_scheduler
    import juggle_pkg::*;
#(
    parameter int MAX_BALLS   = 7,
    parameter int TABLE_DEPTH = 8
) (
    input  logic                                    clk_in,
    input  logic                                    rst_in,
    input  logic                                    new_beat,
    input  logic                                    enable_in,
    input  logic [MAX_PATTERN_LEN-1:0][HEIGHT_W-1:0] pattern_in,
    input  logic [2:0]                              pattern_length,
    input  logic                                    pattern_valid_in,
    output logic                                    throw_valid_out,
    output logic [BALL_ID_W-1:0]                    throw_ball_out,
    output logic [HEIGHT_W-1:0]                     throw_height_out,
    output logic                                    throw_hand_out,
    output logic [2:0]                              balls_in_play_out,
    output logic [2:0]                              beat_index_out,
    output logic                                    running_out,
    output logic                                    error_out
);

    localparam int PTR_W = $clog2(TABLE_DEPTH);
    localparam logic [BALL_ID_W-1:0] MAX_ID = BALL_ID_W'(MAX_BALLS);

    sched_state_t state_reg, state_next;

    logic [MAX_PATTERN_LEN-1:0][HEIGHT_W-1:0] shadow_reg;
    logic [2:0]           shadow_len_reg;
    logic [PTR_W-1:0]     ptr_reg;
    logic [2:0]           idx_reg;
    logic [BALL_ID_W-1:0] next_id_reg;
    logic                 hand_reg;

    logic                 throw_valid_reg;
    logic [BALL_ID_W-1:0] throw_ball_reg;
    logic [HEIGHT_W-1:0]  throw_height_reg;
    logic                 throw_hand_reg;
    logic [2:0]           beat_index_reg;

    logic [HEIGHT_W-1:0]  cur_height;
    slot_t                cur_slot;
    logic [PTR_W:0]       dest_sum;
    logic [PTR_W-1:0]     dest_addr;
    logic                 dest_occupied;

    logic                 load_pattern;
    logic                 go_idle;
    logic                 advance;
    logic                 do_throw;
    logic                 new_ball;
    logic                 clr_en;
    logic [BALL_ID_W-1:0] throw_id;

    assign cur_height = shadow_reg[idx_reg];
    // ptr + h is formed one bit wider and wrapped to the table size
    assign dest_sum   = (PTR_W + 1)'(ptr_reg) + (PTR_W + 1)'(cur_height);
    assign dest_addr  = dest_sum[PTR_W-1:0];

    landing_table #(
        .TABLE_DEPTH (TABLE_DEPTH)
    ) u_table (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .clear_all   (go_idle),
        .rd_addr     (ptr_reg),
        .rd_slot     (cur_slot),
        .clr_en      (clr_en),
        .clr_addr    (ptr_reg),
        .wr_en       (do_throw),
        .wr_addr     (dest_addr),
        .wr_id       (throw_id),
        .wr_occupied (dest_occupied)
    );

    always_comb begin
        state_next   = state_reg;
        load_pattern = 1'b0;
        go_idle      = 1'b0;
        advance      = 1'b0;
        do_throw     = 1'b0;
        new_ball     = 1'b0;
        clr_en       = 1'b0;
        throw_id     = '0;

        if ((state_reg != IDLE) && !enable_in) begin
            go_idle    = 1'b1;
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (enable_in && pattern_valid_in && (pattern_length != 3'd0)) begin
                        load_pattern = 1'b1;
                        state_next   = RUN;
                    end
                end
                RUN: begin
                    if (new_beat) begin
                        if (cur_height != '0) begin
                            if (cur_slot.valid) begin
                                throw_id = cur_slot.id;
                                do_throw = 1'b1;
                                clr_en   = 1'b1;
                            end else if (next_id_reg == MAX_ID) begin
                                state_next = ERROR;
                            end else begin
                                throw_id = next_id_reg;
                                do_throw = 1'b1;
                                new_ball = 1'b1;
                            end
                        end else if (cur_slot.valid) begin
                            state_next = ERROR;
                        end
`ifdef JUGGLE_COLLISION_CHECK_EN
                        if (do_throw && dest_occupied && (dest_addr != ptr_reg)) begin
                            do_throw   = 1'b0;
                            new_ball   = 1'b0;
                            clr_en     = 1'b0;
                            state_next = ERROR;
                        end
`endif
                        advance = (state_next == RUN);
                    end
                end
                ERROR:   state_next = ERROR;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_reg        <= IDLE;
            shadow_reg       <= '0;
            shadow_len_reg   <= '0;
            ptr_reg          <= '0;
            idx_reg          <= '0;
            next_id_reg      <= '0;
            hand_reg         <= 1'b0;
            throw_valid_reg  <= 1'b0;
            throw_ball_reg   <= '0;
            throw_height_reg <= '0;
            throw_hand_reg   <= 1'b0;
            beat_index_reg   <= '0;
        end else begin
            state_reg       <= state_next;
            throw_valid_reg <= do_throw;

            if (go_idle) begin
                ptr_reg          <= '0;
                idx_reg          <= '0;
                next_id_reg      <= '0;
                hand_reg         <= 1'b0;
                throw_ball_reg   <= '0;
                throw_height_reg <= '0;
                throw_hand_reg   <= 1'b0;
                beat_index_reg   <= '0;
            end

            if (load_pattern) begin
                shadow_reg     <= pattern_in;
                shadow_len_reg <= pattern_length;
            end

            if (new_ball) begin
                next_id_reg <= next_id_reg + 1'b1;
            end

            if (advance) begin
                throw_ball_reg   <= throw_id;
                throw_height_reg <= cur_height;
                throw_hand_reg   <= hand_reg;
                beat_index_reg   <= idx_reg;
                ptr_reg          <= ptr_reg + 1'b1;
                idx_reg          <= (idx_reg + 3'd1 == shadow_len_reg) ? 3'd0 : idx_reg + 3'd1;
                hand_reg         <= ~hand_reg;
            end
        end
    end

    assign throw_valid_out   = throw_valid_reg;
    assign throw_ball_out    = throw_ball_reg;
    assign throw_height_out  = throw_height_reg;
    assign throw_hand_out    = throw_hand_reg;
    assign beat_index_out    = beat_index_reg;
    assign balls_in_play_out = next_id_reg;
    assign running_out       = (state_reg == RUN);
    assign error_out         = (state_reg == ERROR);

endmodule

// File: tb/tb_juggle_scheduler.sv
// Directed self-checking bench for juggle_scheduler; build with or without
// JUGGLE_COLLISION_CHECK_EN to exercise both collision behaviours.
module tb_juggle_scheduler;

    logic             clk = 1'b0;
    logic             rst_in;
    logic             new_beat;
    logic             enable_in;
    logic [6:0][2:0]  pattern_in;
    logic [2:0]       pattern_length;
    logic             pattern_valid_in;
    logic             throw_valid_out;
    logic [2:0]       throw_ball_out;
    logic [2:0]       throw_height_out;
    logic             throw_hand_out;
    logic [2:0]       balls_in_play_out;
    logic [2:0]       beat_index_out;
    logic             running_out;
    logic             error_out;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    juggle_scheduler dut (
        .clk_in            (clk),
        .rst_in            (rst_in),
        .new_beat          (new_beat),
        .enable_in         (enable_in),
        .pattern_in        (pattern_in),
        .pattern_length    (pattern_length),
        .pattern_valid_in  (pattern_valid_in),
        .throw_valid_out   (throw_valid_out),
        .throw_ball_out    (throw_ball_out),
        .throw_height_out  (throw_height_out),
        .throw_hand_out    (throw_hand_out),
        .balls_in_play_out (balls_in_play_out),
        .beat_index_out    (beat_index_out),
        .running_out       (running_out),
        .error_out         (error_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0][2:0] mkpat(input int a, input int b, input int c);
        logic [6:0][2:0] p;
        p    = '0;
        p[0] = 3'(a);
        p[1] = 3'(b);
        p[2] = 3'(c);
        return p;
    endfunction

    task automatic start(input logic [6:0][2:0] p, input logic [2:0] len);
        pattern_in       = p;
        pattern_length   = len;
        pattern_valid_in = 1'b1;
        enable_in        = 1'b1;
        @(posedge clk); #1;
        chk("start_running", running_out, 1);
    endtask

    // One strobe, check the registered throw, then confirm the pulse is one cycle wide.
    task automatic beat(input string tag, input logic ev, input logic [2:0] eb,
                        input logic [2:0] eh, input logic ehand, input logic [2:0] eidx);
        new_beat = 1'b1;
        @(posedge clk); #1;
        new_beat = 1'b0;
        $display("[TB] %s valid=%0d ball=%0d h=%0d hand=%0d idx=%0d balls=%0d err=%0d",
                 tag, throw_valid_out, throw_ball_out, throw_height_out, throw_hand_out,
                 beat_index_out, balls_in_play_out, error_out);
        chk({tag, "_valid"}, throw_valid_out, ev);
        if (ev) begin
            chk({tag, "_ball"}, throw_ball_out, eb);
            chk({tag, "_height"}, throw_height_out, eh);
            chk({tag, "_hand"}, throw_hand_out, ehand);
            chk({tag, "_idx"}, beat_index_out, eidx);
        end
        @(posedge clk); #1;
        chk({tag, "_pulse_end"}, throw_valid_out, 0);
    endtask

    task automatic stop(input string tag);
        enable_in        = 1'b0;
        pattern_valid_in = 1'b0;
        @(posedge clk); #1;
        $display("[TB] %s disable running=%0d balls=%0d err=%0d", tag, running_out,
                 balls_in_play_out, error_out);
        chk({tag, "_off_running"}, running_out, 0);
        chk({tag, "_off_balls"}, balls_in_play_out, 0);
        chk({tag, "_off_error"}, error_out, 0);
        chk({tag, "_off_idx"}, beat_index_out, 0);
        chk({tag, "_off_hand"}, throw_hand_out, 0);
    endtask

    initial begin
        rst_in           = 1'b1;
        new_beat         = 1'b0;
        enable_in        = 1'b0;
        pattern_in       = '0;
        pattern_length   = '0;
        pattern_valid_in = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        chk("rst_valid", throw_valid_out, 0);
        chk("rst_ball", throw_ball_out, 0);
        chk("rst_height", throw_height_out, 0);
        chk("rst_balls", balls_in_play_out, 0);
        chk("rst_running", running_out, 0);
        chk("rst_error", error_out, 0);
        rst_in = 1'b0;
        @(posedge clk); #1;

        // length 0 must not start
        pattern_in = mkpat(3, 0, 0); pattern_length = 3'd0;
        pattern_valid_in = 1'b1; enable_in = 1'b1;
        @(posedge clk); #1;
        chk("len0_idle", running_out, 0);
        enable_in = 1'b0;
        @(posedge clk); #1;

        // cascade {3}
        start(mkpat(3, 0, 0), 3'd1);
        beat("c3_b0", 1, 0, 3, 0, 0);
        beat("c3_b1", 1, 1, 3, 1, 0);
        beat("c3_b2", 1, 2, 3, 0, 0);
        beat("c3_b3", 1, 0, 3, 1, 0);
        beat("c3_b4", 1, 1, 3, 0, 0);
        beat("c3_b5", 1, 2, 3, 1, 0);
        chk("c3_balls", balls_in_play_out, 3);
        chk("c3_error", error_out, 0);
        stop("c3");

        // {4,4,1}
        start(mkpat(4, 4, 1), 3'd3);
        beat("p441_b0", 1, 0, 4, 0, 0);
        beat("p441_b1", 1, 1, 4, 1, 1);
        beat("p441_b2", 1, 2, 1, 0, 2);
        beat("p441_b3", 1, 2, 4, 1, 0);
        beat("p441_b4", 1, 0, 4, 0, 1);
        beat("p441_b5", 1, 1, 1, 1, 2);
        beat("p441_b6", 1, 1, 4, 0, 0);
        beat("p441_b7", 1, 2, 4, 1, 1);
        beat("p441_b8", 1, 0, 1, 0, 2);
        chk("p441_balls", balls_in_play_out, 3);
        chk("p441_error", error_out, 0);
        stop("p441");

        // {2,0}: empty hand on beat 1
        start(mkpat(2, 0, 0), 3'd2);
        beat("p20_b0", 1, 0, 2, 0, 0);
        beat("p20_b1", 0, 0, 0, 0, 0);
        beat("p20_b2", 1, 0, 2, 0, 0);
        chk("p20_balls", balls_in_play_out, 1);
        chk("p20_error", error_out, 0);
        stop("p20");

        // {2,1}: two balls land on slot 2
        start(mkpat(2, 1, 0), 3'd2);
        beat("p21_b0", 1, 0, 2, 0, 0);
`ifdef JUGGLE_COLLISION_CHECK_EN
        beat("p21_b1", 0, 0, 0, 0, 0);
        chk("p21_error", error_out, 1);
        chk("p21_running", running_out, 0);
        beat("p21_b2_held", 0, 0, 0, 0, 0);
        chk("p21_error_sticky", error_out, 1);
`else
        beat("p21_b1", 1, 1, 1, 1, 1);
        beat("p21_b2", 1, 1, 2, 0, 0);
        chk("p21_error", error_out, 0);
        chk("p21_balls", balls_in_play_out, 2);
`endif
        stop("p21");

        // disable mid-run, then re-enable with {5,3,1}; later input changes ignored
        start(mkpat(3, 0, 0), 3'd1);
        beat("mid_b0", 1, 0, 3, 0, 0);
        beat("mid_b1", 1, 1, 3, 1, 0);
        beat("mid_b2", 1, 2, 3, 0, 0);
        beat("mid_b3", 1, 0, 3, 1, 0);
        stop("mid");
        start(mkpat(5, 3, 1), 3'd3);
        pattern_in     = mkpat(7, 7, 7);
        pattern_length = 3'd1;
        beat("p531_b0", 1, 0, 5, 0, 0);
        beat("p531_b1", 1, 1, 3, 1, 1);
        beat("p531_b2", 1, 2, 1, 0, 2);
        chk("p531_balls", balls_in_play_out, 3);

        // reset mid-run with a coincident beat
        rst_in   = 1'b1;
        new_beat = 1'b1;
        @(posedge clk); #1;
        new_beat = 1'b0;
        $display("[TB] rst_mid valid=%0d ball=%0d h=%0d balls=%0d run=%0d", throw_valid_out,
                 throw_ball_out, throw_height_out, balls_in_play_out, running_out);
        chk("rstm_valid", throw_valid_out, 0);
        chk("rstm_ball", throw_ball_out, 0);
        chk("rstm_height", throw_height_out, 0);
        chk("rstm_hand", throw_hand_out, 0);
        chk("rstm_idx", beat_index_out, 0);
        chk("rstm_balls", balls_in_play_out, 0);
        chk("rstm_running", running_out, 0);
        chk("rstm_error", error_out, 0);
        rst_in    = 1'b0;
        enable_in = 1'b0;
        @(posedge clk); #1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
